mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single SRAM-like memory port between the fetch stage (instruction requester) and the execute/memory stages (data requester). It accepts one request at a time, forwards it to the memory port, and routes the response to its owner. Data accesses have priority, with a starvation guard that ensures instruction fetch always progresses. On pipeline flush it silently drops the response of an in-flight fetch.

## Interface
Parameters:
- `STARVE_MAX`, default 4: consecutive data grants allowed while `inst_req` is pending before one instruction grant is forced.

Ports (`I`/`D`/`M` = instruction side / data side / memory side; `flush` is the CP0 pipeline flush):
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: marks an in-flight instruction transaction for discard.
- `inst_req` in 1, `inst_addr` in 32: fetch request (always a read of size 2).
- `inst_addr_ok` out 1, `inst_data_ok` out 1, `inst_rdata` out 32: fetch handshake and read data.
- `data_req` in 1, `data_wr` in 1, `data_size` in 2, `data_wstrb` in 4, `data_addr` in 32, `data_wdata` in 32: data request.
- `data_addr_ok` out 1, `data_data_ok` out 1, `data_rdata` out 32: data handshake and read data.
- `m_req` out 1, `m_wr` out 1, `m_size` out 2, `m_wstrb` out 4, `m_addr` out 32, `m_wdata` out 32: memory-side request, all registered.
- `m_addr_ok` in 1, `m_data_ok` in 1, `m_rdata` in 32: memory-side handshake and read data.

## Operation
- States: `IDLE`, `REQ`, `RESP`. Owner register `own` takes the value I or D.
- **IDLE**, arbitration:
  - `flush` suppresses `inst_req` for this cycle.
  - If only one side is requesting, that side is granted.
  - If both are requesting, D is granted unless `starve_cnt == STARVE_MAX`, in which case I is granted.
  - On a grant:
    - Assert the owner's `*_addr_ok` combinationally in the same cycle.
    - Latch the request fields into the `m_*` registers. For an I grant, latch `m_wr=0`, `m_size=2`, `m_wstrb=0`, `m_wdata=0`.
    - Set `own` and move to `REQ`.
- **REQ**:
  - `m_req=1`; all `m_*` fields are held stable.
  - On `m_addr_ok`: `m_req` drops the next cycle, state moves to `RESP`.
  - The request is never withdrawn, even on `flush`.
- **RESP**:
  - Wait for `m_data_ok`.
  - The owner's `*_data_ok = m_data_ok && !discard`, and its `*_rdata = m_rdata` passes through combinationally. The non-owner's `*_data_ok` is 0.
  - On `m_data_ok`: return to `IDLE` and clear `discard`.
- **discard**:
  - Set when `flush` is high while `own==I` and the state is `REQ` or `RESP`.
  - Never set for D transactions.
  - A `flush` in the same cycle as `m_data_ok` in `RESP` suppresses that `inst_data_ok`.
- **starve_cnt** (3 bits, saturating):
  - Incremented on each D grant made while `inst_req` (not flushed) is high.
  - Cleared on any I grant.
  - Unchanged on a D grant with no competing `inst_req`.
- `*_rdata` is 0 when the corresponding `*_data_ok` is 0.

## Timing
- Reset values:
  - State is `IDLE`, `own=I`, `discard=0`, `starve_cnt=0`.
  - `m_req=0`; all other `m_*` outputs are 0.
  - All `*_addr_ok` and `*_data_ok` outputs are 0.
- Reset mid-transaction abandons the transaction with no response to either requester. Memory-side cleanup is the slave's responsibility, since it shares the same reset.
- Minimum latency:
  - Grant/`addr_ok` at cycle 0.
  - `m_req` at cycle 1; with `m_addr_ok` at cycle 1, the state is `RESP` at cycle 2.
  - `m_data_ok` at cycle 2 gives `data_ok` at cycle 2.
  - The next grant is possible at cycle 3.
- Only one transaction is outstanding. `*_addr_ok` is never asserted outside `IDLE`.
- `m_addr_ok` arriving while not in `REQ`, and `m_data_ok` arriving while not in `RESP`, are ignored.

## Test plan
- Single fetch, `inst_addr=0xBFC00000`, slave with 0 wait states:
  - `inst_addr_ok` at cycle 0.
  - `m_req`, `m_addr=0xBFC00000`, `m_wr=0` at cycle 1.
  - `inst_data_ok` with `inst_rdata` equal to the slave data at cycle 2.
- Data store, `size=2`, `wstrb=0xF`, `addr=0x1000`, `wdata=0xDEADBEEF`:
  - Slave with 2-cycle `addr_ok` delay: `m_*` are held stable for 3 cycles of `m_req`.
  - `data_data_ok` pulses once; `inst_data_ok` stays 0.
- Both requesters held high continuously (`STARVE_MAX=4`): the grant sequence is D, D, D, D, I, D, D, D, D, I.
- Fetch in flight with `flush` pulsed in `RESP`, one cycle before `m_data_ok`:
  - No `inst_data_ok` is produced.
  - The next `IDLE` grants the pending data request normally.
- `flush` in `IDLE` with both `inst_req` and `data_req` high at `starve_cnt=4`: D is granted and `inst_addr_ok` stays 0.
- `reset` asserted in `RESP`: the next cycle shows `m_req=0`, all `ok` outputs 0, and state `IDLE`. A new fetch after reset completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one SRAM-like memory port between fetch and data requesters
//
// Purpose:
//   Accepts one request at a time from either the instruction (fetch) side or
//   the data side, forwards it through registered m_* outputs, and routes the
//   single response back to whichever side owns the transaction. Data wins
//   arbitration unless instruction fetch has lost STARVE_MAX times in a row.
//   A flush discards the response of an in-flight fetch without withdrawing
//   the memory request.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   flush                       pipeline flush; kills in-flight fetch response
//   inst_req/inst_addr          fetch request (always a 32-bit read)
//   inst_addr_ok/data_ok/rdata  fetch grant, response strobe, read data
//   data_req/wr/size/wstrb/
//   data_addr/data_wdata        data request
//   data_addr_ok/data_ok/rdata  data grant, response strobe, read data
//   m_req/wr/size/wstrb/
//   m_addr/m_wdata              registered memory-side request
//   m_addr_ok/m_data_ok/m_rdata memory-side handshake and read data

module mem_bus_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } own_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  localparam logic [2:0] CNT_SAT    = 3'd7;

  state_t     state;
  state_t     state_nxt;
  own_t       own;
  logic       discard;
  logic [2:0] starve_cnt;

  logic       inst_live;
  logic       starved;
  logic       grant_i;
  logic       grant_d;
  logic       resp_fire;

  // A flushed fetch request is not a real competitor this cycle: it neither
  // wins a grant nor counts toward starvation.
  assign inst_live = inst_req && !flush;
  assign starved   = (starve_cnt == STARVE_LIM);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state, arbitration and requester-facing outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    resp_fire    = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = '0;
    data_rdata   = '0;

    case (state)
      IDLE: begin
        // Data has priority unless fetch has been passed over STARVE_MAX
        // times while it was waiting.
        if (data_req && !(inst_live && starved)) begin
          grant_d = 1'b1;
        end else if (inst_live) begin
          grant_i = 1'b1;
        end
        if (grant_i || grant_d) begin
          state_nxt = REQ;
        end
      end

      REQ: begin
        if (m_addr_ok) begin
          state_nxt = RESP;
        end
      end

      RESP: begin
        if (m_data_ok) begin
          state_nxt = IDLE;
          resp_fire = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // While reset is held, nothing is granted and nothing is returned; the
    // transaction in flight is simply abandoned.
    if (!reset) begin
      inst_addr_ok = grant_i;
      data_addr_ok = grant_d;
      // A flush coinciding with the response also kills that response, not
      // just later ones.
      inst_data_ok = resp_fire && (own == OWN_I) && !discard && !flush;
      data_data_ok = resp_fire && (own == OWN_D);
    end

    if (inst_data_ok) begin
      inst_rdata = m_rdata;
    end
    if (data_data_ok) begin
      data_rdata = m_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // Memory-side request registers, owner, discard flag, starvation counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      own        <= OWN_I;
      discard    <= 1'b0;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_wr       <= 1'b0;
      m_size     <= '0;
      m_wstrb    <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
    end else begin
      if (grant_i) begin
        own        <= OWN_I;
        m_req      <= 1'b1;
        m_wr       <= 1'b0;
        m_size     <= 2'd2;
        m_wstrb    <= 4'd0;
        m_addr     <= inst_addr;
        m_wdata    <= '0;
        starve_cnt <= '0;
      end else if (grant_d) begin
        own     <= OWN_D;
        m_req   <= 1'b1;
        m_wr    <= data_wr;
        m_size  <= data_size;
        m_wstrb <= data_wstrb;
        m_addr  <= data_addr;
        m_wdata <= data_wdata;
        // Only a D grant that actually beat a live fetch counts as starving it.
        if (inst_live && (starve_cnt != CNT_SAT)) begin
          starve_cnt <= starve_cnt + 3'd1;
        end
      end else if ((state == REQ) && m_addr_ok) begin
        m_req <= 1'b0;
      end

      // The memory request is never withdrawn; a flush only marks the fetch
      // response for silent discard. The response ends the transaction, so it
      // also retires the mark.
      if ((state == RESP) && m_data_ok) begin
        discard <= 1'b0;
      end else if (flush && (own == OWN_I) && ((state == REQ) || (state == RESP))) begin
        discard <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  typedef struct {
    bit          rst, fl, ir, dr, dw, mao, mdo;
    logic [31:0] ia, da, dwd, mrd;
    bit          eiao, eido, edao, eddo, emreq;
    logic [31:0] eird, edrd, emaddr;
    bit          emwr;
    logic [31:0] emwd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, bit fl, bit ir, bit dr, bit dw, bit mao, bit mdo,
                              logic [31:0] ia, logic [31:0] da, logic [31:0] dwd, logic [31:0] mrd,
                              bit eiao, bit eido, bit edao, bit eddo, bit emreq,
                              logic [31:0] eird, logic [31:0] edrd, logic [31:0] emaddr,
                              bit emwr, logic [31:0] emwd);
    vec_t v;
    v.rst = rst; v.fl = fl; v.ir = ir; v.dr = dr; v.dw = dw; v.mao = mao; v.mdo = mdo;
    v.ia = ia; v.da = da; v.dwd = dwd; v.mrd = mrd;
    v.eiao = eiao; v.eido = eido; v.edao = edao; v.eddo = eddo; v.emreq = emreq;
    v.eird = eird; v.edrd = edrd; v.emaddr = emaddr; v.emwr = emwr; v.emwd = emwd;
    tbl.push_back(v);
  endfunction

  task automatic check(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [127:0] act_ok();
    return 128'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, m_req, inst_rdata, data_rdata});
  endfunction

  function automatic logic [127:0] act_m();
    return 128'({m_addr, m_wr, m_size, m_wstrb, m_wdata});
  endfunction

  task automatic idle_inputs();
    flush = 0; inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 2; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  // Both requesters held high; slave answers with no wait states.
  // Returns {data_addr_ok, inst_addr_ok} as seen in the arbitration cycle.
  task automatic txn_both(input bit fl, output logic [1:0] who);
    inst_req = 1; inst_addr = 32'hBFC0_0000; data_req = 1; data_wr = 0; data_addr = 32'h3000;
    flush = fl; m_addr_ok = 0; m_data_ok = 0;
    @(negedge clk);
    who = {data_addr_ok, inst_addr_ok};
    @(posedge clk); #1;
    flush = 0; m_addr_ok = 1;
    @(posedge clk); #1;
    m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h1234;
    @(posedge clk); #1;
    m_data_ok = 0;
  endtask

  // Reference model state for random traffic (transaction level).
  bit          md_busy, md_wait_a, md_own_d, md_drop;
  int          md_cnt;
  logic [70:0] md_fields;

  initial begin
    logic [1:0] who;
    logic [1:0] starve_exp [10];
    bit i_pend, d_pend;
    logic [31:0] i_a, d_a, d_wd;
    bit d_w;
    logic [1:0] d_sz;
    logic [3:0] d_st;

    reset = 1;
    idle_inputs();

    // Directed per-cycle vectors.
    // fetch, zero wait states
    add(0,0,1,0,0,0,0, 32'hBFC00000,0,0,0,            1,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,1,0, 0,0,0,0,                        0,0,0,0,1, 0,0,32'hBFC00000,0,0);
    add(0,0,0,0,0,0,1, 0,0,0,32'h3C08BFC0,             0,1,0,0,0, 32'h3C08BFC0,0,0,0,0);
    add(0,0,0,0,0,1,1, 0,0,0,32'h11111111,             0,0,0,0,0, 0,0,0,0,0);
    // store, addr_ok delayed 2 cycles, fetch waiting meanwhile gets no addr_ok
    add(0,0,0,1,1,0,0, 0,32'h1000,32'hDEADBEEF,0,      0,0,1,0,0, 0,0,0,0,0);
    add(0,0,1,0,0,0,0, 4,0,0,0,                        0,0,0,0,1, 0,0,32'h1000,1,32'hDEADBEEF);
    add(0,0,1,0,0,0,0, 4,0,0,0,                        0,0,0,0,1, 0,0,32'h1000,1,32'hDEADBEEF);
    add(0,0,1,0,0,1,0, 4,0,0,0,                        0,0,0,0,1, 0,0,32'h1000,1,32'hDEADBEEF);
    add(0,0,1,0,0,1,0, 4,0,0,0,                        0,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,0,1, 0,0,0,32'h12345678,             0,0,0,1,0, 0,32'h12345678,0,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,0,                        0,0,0,0,0, 0,0,0,0,0);
    // fetch flushed in RESP one cycle before data_ok; pending data goes next
    add(0,0,1,0,0,0,0, 32'hBFC00004,0,0,0,             1,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,1,0,1,0, 0,32'h2000,0,0,                 0,0,0,0,1, 0,0,32'hBFC00004,0,0);
    add(0,1,0,1,0,0,0, 0,32'h2000,0,0,                 0,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,1,0,0,1, 0,32'h2000,0,32'hAAAA5555,      0,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,1,0,0,0, 0,32'h2000,0,0,                 0,0,1,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,1,0, 0,0,0,0,                        0,0,0,0,1, 0,0,32'h2000,0,0);
    add(0,0,0,0,0,0,1, 0,0,0,32'h55AA55AA,             0,0,0,1,0, 0,32'h55AA55AA,0,0,0);
    // flush together with data_ok, then a clean fetch
    add(0,0,1,0,0,0,0, 32'h100,0,0,0,                  1,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,1,0, 0,0,0,0,                        0,0,0,0,1, 0,0,32'h100,0,0);
    add(0,1,0,0,0,0,1, 0,0,0,32'h77777777,             0,0,0,0,0, 0,0,0,0,0);
    add(0,0,1,0,0,0,0, 32'h104,0,0,0,                  1,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,1,0, 0,0,0,0,                        0,0,0,0,1, 0,0,32'h104,0,0);
    add(0,0,0,0,0,0,1, 0,0,0,32'h0BADF00D,             0,1,0,0,0, 32'h0BADF00D,0,0,0,0);
    // reset in RESP, stray handshakes after, then a fetch completes
    add(0,0,1,0,0,0,0, 32'h200,0,0,0,                  1,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,1,0, 0,0,0,0,                        0,0,0,0,1, 0,0,32'h200,0,0);
    add(1,0,1,1,0,0,1, 32'h300,32'h300,0,32'h99,       0,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,1,1, 0,0,0,32'h99,                   0,0,0,0,0, 0,0,0,0,0);
    add(0,0,1,0,0,0,0, 32'hBFC00000,0,0,0,             1,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,1,0, 0,0,0,0,                        0,0,0,0,1, 0,0,32'hBFC00000,0,0);
    add(0,0,0,0,0,0,1, 0,0,0,32'hCAFEF00D,             0,1,0,0,0, 32'hCAFEF00D,0,0,0,0);

    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("reset_state", 0, act_ok(), 128'd0);
    check("reset_mfields", 0, act_m(), 128'd0);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      reset = tbl[i].rst; flush = tbl[i].fl;
      inst_req = tbl[i].ir; inst_addr = tbl[i].ia;
      data_req = tbl[i].dr; data_wr = tbl[i].dw; data_size = 2;
      data_wstrb = tbl[i].dw ? 4'hF : 4'h0; data_addr = tbl[i].da; data_wdata = tbl[i].dwd;
      m_addr_ok = tbl[i].mao; m_data_ok = tbl[i].mdo; m_rdata = tbl[i].mrd;
      @(negedge clk);
      check("vec_ok", i, act_ok(),
            128'({tbl[i].eiao, tbl[i].eido, tbl[i].edao, tbl[i].eddo, tbl[i].emreq, tbl[i].eird, tbl[i].edrd}));
      if (tbl[i].emreq)
        check("vec_mfields", i, act_m(),
              128'({tbl[i].emaddr, tbl[i].emwr, 2'd2, (tbl[i].emwr ? 4'hF : 4'h0), tbl[i].emwd}));
      @(posedge clk); #1;
    end
    idle_inputs();
    reset = 0;

    // Both requesters continuously: D x4 then I, twice.
    starve_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      txn_both(0, who);
      check("starve_seq", k, 128'(who), 128'(starve_exp[k]));
    end

    // Fetch starved to the limit, then flushed at arbitration: D still wins.
    do_reset();
    for (int k = 0; k < 4; k++) txn_both(0, who);
    txn_both(1, who);
    check("flush_at_starve", 0, 128'(who), 128'(2'b10));
    txn_both(0, who);
    check("after_flush_starve", 0, 128'(who), 128'(2'b01));

    // Randomized traffic against a transaction-level model.
    do_reset();
    md_busy = 0; md_wait_a = 0; md_own_d = 0; md_drop = 0; md_cnt = 0; md_fields = '0;
    i_pend = 0; d_pend = 0; i_a = 0; d_a = 0; d_wd = 0; d_w = 0; d_sz = 0; d_st = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit rst, fl, live_i, g_i, g_d, e_ido, e_ddo;
      logic [31:0] e_rd;
      if (!i_pend && ($urandom_range(0, 2) == 0)) begin
        i_pend = 1; i_a = $urandom;
      end
      if (!d_pend && ($urandom_range(0, 2) == 0)) begin
        d_pend = 1; d_a = $urandom; d_wd = $urandom; d_w = 1'($urandom);
        d_sz = 2'($urandom_range(0, 2)); d_st = 4'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      reset = rst; flush = fl;
      inst_req = i_pend; inst_addr = i_a;
      data_req = d_pend; data_wr = d_w; data_size = d_sz; data_wstrb = d_st;
      data_addr = d_a; data_wdata = d_wd;
      m_addr_ok = 1'($urandom); m_data_ok = ($urandom_range(0, 2) == 0); m_rdata = $urandom;

      g_i = 0; g_d = 0; e_ido = 0; e_ddo = 0; e_rd = 0;
      live_i = i_pend && !fl;
      if (!rst) begin
        if (!md_busy) begin
          if (d_pend && !(live_i && md_cnt == STARVE)) g_d = 1;
          else if (live_i) g_i = 1;
        end else if (!md_wait_a && m_data_ok) begin
          if (md_own_d) begin
            e_ddo = 1; e_rd = m_rdata;
          end else if (!md_drop && !fl) begin
            e_ido = 1; e_rd = m_rdata;
          end
        end
      end

      @(negedge clk);
      check("rand_ok", cyc, act_ok(),
            128'({g_i, e_ido, g_d, e_ddo, (md_busy && md_wait_a),
                  (e_ido ? e_rd : 32'd0), (e_ddo ? e_rd : 32'd0)}));
      if (md_busy && md_wait_a) check("rand_mfields", cyc, act_m(), 128'(md_fields));

      if (rst) begin
        md_busy = 0; md_wait_a = 0; md_drop = 0; md_cnt = 0;
      end else if (!md_busy) begin
        if (g_i) begin
          md_busy = 1; md_wait_a = 1; md_own_d = 0; md_drop = 0; md_cnt = 0;
          md_fields = {i_a, 1'b0, 2'd2, 4'd0, 32'd0};
          i_pend = 0;
        end else if (g_d) begin
          md_busy = 1; md_wait_a = 1; md_own_d = 1; md_drop = 0;
          if (live_i && md_cnt < 7) md_cnt++;
          md_fields = {d_a, d_w, d_sz, d_st, d_wd};
          d_pend = 0;
        end
      end else if (md_wait_a) begin
        if (fl && !md_own_d) md_drop = 1;
        if (m_addr_ok) md_wait_a = 0;
      end else begin
        if (m_data_ok) begin
          md_busy = 0; md_drop = 0;
        end else if (fl && !md_own_d) begin
          md_drop = 1;
        end
      end
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
